reg_scoreboard: RTL

//   Parametrised register scoreboard for the multi-unit core: tracks pending register writes from

---
 rtl/core_pkg.sv | 36 +++
 rtl/sb_entry.sv | 70 +++++++
 rtl/reg_scoreboard.sv | 129 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core constants: register-file geometry, scoreboard defaults and
// per-unit writeback latencies used by decode to fill issue_lat.
package core_pkg;

    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int LW      = 4;
    localparam int FWD     = 1;
    localparam int MAX_VAR = 4;

    localparam logic [LW-1:0] LAT_ALU = 4'd1;
    localparam logic [LW-1:0] LAT_MUL = 4'd3;
    localparam logic [LW-1:0] LAT_FPU = 4'd4;
    localparam logic [LW-1:0] LAT_VAR = 4'd0;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_MUL = 2'd1,
        UNIT_FPU = 2'd2,
        UNIT_MEM = 2'd3
    } unit_e;

    // Map an execution unit to the latency decode presents on issue_lat.
    function automatic logic [LW-1:0] unit_latency(input unit_e unit);
        logic [LW-1:0] lat;
        case (unit)
            UNIT_ALU: lat = LAT_ALU;
            UNIT_MUL: lat = LAT_MUL;
            UNIT_FPU: lat = LAT_FPU;
            UNIT_MEM: lat = LAT_VAR;
            default:  lat = LAT_VAR;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: pending-write flag, variable-latency flag and the
// cycles-to-writeback countdown for a single architectural register.
module sb_entry #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_fix,
    input  logic          set_var,
    input  logic [CW-1:0] lat,
    input  logic          clr_var,
    output logic          busy,
    output logic          is_var,
    output logic [CW-1:0] cnt
);

    logic          busy_r;
    logic          var_r;
    logic [CW-1:0] cnt_r;
    logic          busy_s;
    logic          var_s;
    logic [CW-1:0] cnt_s;

    // Next-state: a new issue overrides any countdown finishing this cycle.
    always_comb begin
        busy_s = busy_r;
        var_s  = var_r;
        cnt_s  = cnt_r;
        if (set_fix) begin
            busy_s = 1'b1;
            var_s  = 1'b0;
            cnt_s  = lat;
        end else if (set_var) begin
            busy_s = 1'b1;
            var_s  = 1'b1;
            cnt_s  = {CW{1'b0}};
        end else if (clr_var) begin
            busy_s = 1'b0;
            var_s  = 1'b0;
            cnt_s  = {CW{1'b0}};
        end else if (busy_r && !var_r) begin
            if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
                busy_s = 1'b0;
                cnt_s  = {CW{1'b0}};
            end else begin
                cnt_s  = cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            busy_s = busy_r;
        end
    end

    // Slot state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            var_r  <= 1'b0;
            cnt_r  <= {CW{1'b0}};
        end else begin
            busy_r <= busy_s;
            var_r  <= var_s;
            cnt_r  <= cnt_s;
        end
    end

    assign busy   = busy_r;
    assign is_var = var_r;
    assign cnt    = cnt_r;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard between decode and issue: records pending writes from
// fixed- and variable-latency units and holds issue on RAW/WAW/structural hazards.
module reg_scoreboard #(
    parameter int NREG    = core_pkg::NREG,
    parameter int AW      = core_pkg::AW,
    parameter int LW      = core_pkg::LW,
    parameter int FWD     = core_pkg::FWD,
    parameter int MAX_VAR = core_pkg::MAX_VAR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    input  logic            issue_use1,
    input  logic            issue_use2,
    input  logic            issue_wr,
    input  logic [AW-1:0]   issue_rd,
    input  logic [LW-1:0]   issue_lat,
    input  logic            cmp_valid,
    input  logic [AW-1:0]   cmp_rd,
    output logic [NREG-1:0] busy_vec,
    output logic [2:0]      var_cnt,
    output logic            err
);

    logic [NREG-1:0] busy_s;
    logic [NREG-1:0] var_s;
    logic [LW-1:0]   cnt_s [NREG];

    logic       accept_s;
    logic       wr_live_s;
    logic       lat_zero_s;
    logic       cmp_hit_s;
    logic       var_inc_s;
    logic       raw1_s;
    logic       raw2_s;
    logic       waw_s;
    logic       struct_s;
    logic [2:0] var_cnt_r;
    logic       err_r;

    assign accept_s   = issue_valid & issue_ready;
    assign wr_live_s  = issue_wr & (issue_rd != {AW{1'b0}});
    assign lat_zero_s = (issue_lat == {LW{1'b0}});
    assign cmp_hit_s  = cmp_valid & busy_s[cmp_rd] & var_s[cmp_rd];
    assign var_inc_s  = accept_s & wr_live_s & lat_zero_s;

    // Register 0 is never written: its slot only ever sees zero enables.
    for (genvar g = 0; g < NREG; g++) begin : g_entry
        logic sel_s;
        assign sel_s = accept_s & wr_live_s & (issue_rd == AW'(g));

        sb_entry #(
            .CW (LW)
        ) u_entry (
            .clk     (clk),
            .rst     (rst),
            .set_fix (sel_s & ~lat_zero_s),
            .set_var (sel_s & lat_zero_s),
            .lat     (issue_lat),
            .clr_var (cmp_hit_s & (cmp_rd == AW'(g))),
            .busy    (busy_s[g]),
            .is_var  (var_s[g]),
            .cnt     (cnt_s[g])
        );
    end

    // Hazard detection from registered state only, so a completion arriving
    // this cycle cannot release the stall it is about to clear.
    always_comb begin
        raw1_s   = 1'b0;
        raw2_s   = 1'b0;
        waw_s    = 1'b0;
        struct_s = 1'b0;
        if (issue_use1 && (issue_rs1 != {AW{1'b0}}) && busy_s[issue_rs1]) begin
            raw1_s = var_s[issue_rs1] || (cnt_s[issue_rs1] > LW'(FWD));
        end else begin
            raw1_s = 1'b0;
        end
        if (issue_use2 && (issue_rs2 != {AW{1'b0}}) && busy_s[issue_rs2]) begin
            raw2_s = var_s[issue_rs2] || (cnt_s[issue_rs2] > LW'(FWD));
        end else begin
            raw2_s = 1'b0;
        end
        if (wr_live_s && busy_s[issue_rd]) begin
            waw_s = var_s[issue_rd] || lat_zero_s || (cnt_s[issue_rd] >= issue_lat);
        end else begin
            waw_s = 1'b0;
        end
        if (issue_wr && lat_zero_s) begin
            struct_s = (var_cnt_r == 3'(MAX_VAR));
        end else begin
            struct_s = 1'b0;
        end
    end

    assign issue_ready = ~(raw1_s | raw2_s | waw_s | struct_s);

    // Outstanding variable-latency count; issue and completion together cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            var_cnt_r <= 3'd0;
        end else begin
            case ({var_inc_s, cmp_hit_s})
                2'b10:   var_cnt_r <= var_cnt_r + 3'd1;
                2'b01:   var_cnt_r <= var_cnt_r - 3'd1;
                default: var_cnt_r <= var_cnt_r;
            endcase
        end
    end

    // Sticky error for a completion that matches no variable-latency entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (cmp_valid && !cmp_hit_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign busy_vec = busy_s;
    assign var_cnt  = var_cnt_r;
    assign err      = err_r;

endmodule
